// File: rtl/decimal_to_bcd_keypad_pkg.sv
// Shared definitions for the keypad-to-BCD encoder: key count, BCD limit and
// FSM state encoding.
package decimal_to_bcd_keypad_pkg;

  localparam int         KEY_LINES = 10;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised two-flop synchroniser for asynchronous level inputs, with
// asynchronous active-high reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages sample
  // their pre-edge inputs and the chain really is two flops deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/decimal_to_bcd_keypad.sv
// Ten-line decimal keypad to registered BCD encoder with synchronisation,
// press/release debounce and multi-key detection. Define KEYPAD_PRIORITY_EN
// to encode multi-key presses to the highest key instead of flagging err.
module decimal_to_bcd_keypad
  import decimal_to_bcd_keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_LINES-1:0] D,
  output logic [3:0]           BCD,
  output logic                 valid,
  output logic                 err,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Highest set key wins; the clamp keeps BCD legal even for a corrupt index.
  function automatic logic [3:0] encode_keys(input logic [KEY_LINES-1:0] keys);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < KEY_LINES; i++) begin
      if (keys[i]) idx = 4'(i);
    end
    return (idx > BCD_MAX) ? BCD_MAX : idx;
  endfunction

  logic [KEY_LINES-1:0] s_keys;

  sync_2ff #(
    .WIDTH(KEY_LINES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(D),
    .q_o(s_keys)
  );

  state_e               state_q, state_d;
  logic [KEY_LINES-1:0] cap_q,   cap_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [3:0]           bcd_q,   bcd_d;
  logic                 valid_q, valid_d;
  logic                 err_q,   err_d;
  logic                 busy_q,  busy_d;

  logic [CNT_W-1:0]     cnt_inc;
  logic                 keys_down;
  logic                 keys_same;
  logic [3:0]           cap_code;

  assign cnt_inc   = cnt_q + CNT_ONE;
  assign keys_down = |s_keys;
  assign keys_same = (s_keys == cap_q);
  assign cap_code  = encode_keys(cap_q);

`ifndef KEYPAD_PRIORITY_EN
  logic multi_key;
  assign multi_key = |(cap_q & (cap_q - KEY_LINES'(1)));
`endif

  // NOTE: every always_comb output gets its default first, so no branch can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (keys_down) begin
          cap_d   = s_keys;
          cnt_d   = CNT_ONE;
          state_d = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (!keys_same) begin
          if (!keys_down) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cap_d = s_keys;
            cnt_d = CNT_ONE;
          end
        end else if (cnt_inc >= DB_LIMIT) begin
          cnt_d   = '0;
          state_d = ST_HELD;
`ifdef KEYPAD_PRIORITY_EN
          bcd_d   = cap_code;
          valid_d = 1'b1;
`else
          if (multi_key) begin
            err_d = 1'b1;
          end else begin
            bcd_d   = cap_code;
            valid_d = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_HELD: begin
        // Release needs an unbroken run of empty samples; any key restarts it.
        if (keys_down) begin
          cnt_d = '0;
        end else if (cnt_inc >= DB_LIMIT) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  // NOTE: the capture register is reset along with the control state so the
  // first comparison after reset never sees an undefined key set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign BCD   = bcd_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_decimal_to_bcd_keypad.sv
// Scoreboard bench for decimal_to_bcd_keypad: a run-length reference model
// predicts each accepted press; a negedge monitor checks every output.
module tb_decimal_to_bcd_keypad;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] D;
  logic [3:0] BCD;
  logic       valid;
  logic       err;
  logic       busy;

  always #5 clk = ~clk;

  decimal_to_bcd_keypad #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .D(D),
    .BCD(BCD),
    .valid(valid),
    .err(err),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         edge_n;
    bit         is_err;
    logic [3:0] code;
  } exp_t;

  exp_t sb[$];

  // Reference model state, expressed as run lengths of sampled key sets.
  int         edge_no;
  logic [9:0] d1, d2, prev;
  bit         held;
  int         run, zrun;
  logic [3:0] m_bcd;
  bit         m_busy;

  int valid_cnt = 0;
  int err_cnt   = 0;
  int last_valid_edge = -1;

  function automatic int popc(input logic [9:0] v);
    int n = 0;
    for (int i = 0; i < 10; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic logic [3:0] top_idx(input logic [9:0] v);
    logic [3:0] r = 4'd0;
    for (int i = 0; i < 10; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [9:0] s;
    if (rst) begin
      edge_no = 0; d1 = '0; d2 = '0; prev = '0;
      held = 0; run = 0; zrun = 0; m_bcd = 4'd0; m_busy = 0;
      sb.delete();
    end else begin
      edge_no++;
      s  = d2;          // key set seen by the decision logic at this edge
      d2 = d1;
      d1 = D;
      if (!held) begin
        if (s == 0)         run = 0;
        else if (s == prev) run++;
        else                run = 1;
        prev = s;
        if (run >= N) begin
          held = 1; zrun = 0; run = 0;
          if (popc(s) == 1) begin
            m_bcd = top_idx(s);
            sb.push_back('{edge_no, 1'b0, m_bcd});
          end else begin
`ifdef KEYPAD_PRIORITY_EN
            m_bcd = top_idx(s);
            sb.push_back('{edge_no, 1'b0, m_bcd});
`else
            sb.push_back('{edge_no, 1'b1, m_bcd});
`endif
          end
        end
        m_busy = held || (run > 0);
      end else begin
        if (s == 0) zrun++;
        else        zrun = 0;
        if (zrun >= N) begin
          held = 0; prev = '0;
        end
        m_busy = held;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      check("bcd_track", BCD, m_bcd);
      check("busy_track", busy, m_busy);
      if (valid && err) begin
        checks++; errors++;
        $display("FAIL valid_err_overlap: got valid=1 err=1 expected at most one");
      end
      if (valid || err) begin
        if (valid) begin valid_cnt++; last_valid_edge = edge_no; end
        if (err) err_cnt++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_event: got valid=%0d err=%0d at edge %0d expected none",
                   valid, err, edge_no);
        end else begin
          e = sb.pop_front();
          check("event_edge", edge_no, e.edge_n);
          check("event_is_err", err, e.is_err);
          if (valid) check("event_code", BCD, e.code);
        end
      end else if (sb.size() > 0 && sb[0].edge_n <= edge_no) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_event: got none at edge %0d expected %s", edge_no,
                 e.is_err ? "err" : "valid");
      end
    end
  end

  task automatic drive(input logic [9:0] v, input int n);
    D = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int vs, es;
    logic [9:0] pat;
    rst = 1'b1;
    D   = '0;
    repeat (2) @(negedge clk);
    check("rst_bcd", BCD, 0);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Single key 5: one valid after edge 6.
    vs = valid_cnt;
    drive(10'b0000100000, 20);
    drive('0, 10);
    check("k5_valid_count", valid_cnt - vs, 1);
    check("k5_valid_edge", last_valid_edge, 6);
    check("k5_bcd", BCD, 5);

    // Short key-9 glitch is rejected.
    vs = valid_cnt; es = err_cnt;
    drive(10'b1000000000, 2);
    drive('0, 10);
    check("glitch_valid", valid_cnt - vs, 0);
    check("glitch_err", err_cnt - es, 0);
    check("glitch_busy", busy, 0);
    check("glitch_bcd", BCD, 5);

    // Keys 3 and 7 together.
    vs = valid_cnt; es = err_cnt;
    drive(10'b0010001000, 20);
    drive('0, 10);
`ifdef KEYPAD_PRIORITY_EN
    check("multi_valid", valid_cnt - vs, 1);
    check("multi_err", err_cnt - es, 0);
    check("multi_bcd", BCD, 7);
`else
    check("multi_valid", valid_cnt - vs, 0);
    check("multi_err", err_cnt - es, 1);
    check("multi_bcd", BCD, 5);
`endif

    // Key 2 with bouncy release, then key 8.
    vs = valid_cnt;
    drive(10'b0000000100, 10);
    drive('0, 1);
    drive(10'b0000000100, 1);
    drive('0, 12);
    check("bounce_bcd", BCD, 2);
    drive(10'b0100000000, 10);
    drive('0, 10);
    check("bounce_valid_count", valid_cnt - vs, 2);
    check("k8_bcd", BCD, 8);

    // Reset while key 4 is held, then re-press is accepted again.
    drive(10'b0000010000, 12);
    check("pre_rst_bcd", BCD, 4);
    rst = 1'b1;
    #1;
    check("mid_rst_bcd", BCD, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    @(negedge clk);
    rst = 1'b0;
    vs = valid_cnt;
    drive(10'b0000010000, 15);
    drive('0, 10);
    check("post_rst_valid", valid_cnt - vs, 1);
    check("post_rst_edge", last_valid_edge, 6);
    check("post_rst_bcd", BCD, 4);

    // Sweep 0..9 with full releases.
    vs = valid_cnt; es = err_cnt;
    for (int k = 0; k < 10; k++) begin
      drive(10'(1 << k), 8);
      drive('0, 8);
      check("sweep_bcd", BCD, k);
    end
    check("sweep_valid", valid_cnt - vs, 10);
    check("sweep_err", err_cnt - es, 0);

    // Randomised key activity, checked by the scoreboard.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1:    pat = 10'($urandom_range(1, 1023));
        2:       pat = '0;
        default: pat = 10'(1 << $urandom_range(0, 9));
      endcase
      drive(pat, $urandom_range(1, 10));
      if ($urandom_range(0, 2) == 0) drive('0, $urandom_range(1, 8));
    end
    drive('0, 20);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
